// File: rtl/fix2sgl_pkg.sv
// rtl/fix2sgl_pkg.sv - shared IEEE 754 single-precision constants, types and packing helper
//
// Purpose: common definitions for the fixed-point to single-precision converter.
// Contents:
//   F32_BIAS, F32_MANT_W, F32_EXP_W  single-precision field constants
//   f32_t                            packed {sign, exp, mant} view of a 32-bit float
//   f32_pack()                       builds an f32_t from its three fields
package fix2sgl_pkg;

  localparam int F32_BIAS   = 127;
  localparam int F32_MANT_W = 23;
  localparam int F32_EXP_W  = 8;

  typedef struct packed {
    logic                  sign;
    logic [F32_EXP_W-1:0]  exp;
    logic [F32_MANT_W-1:0] mant;
  } f32_t;

  function automatic f32_t f32_pack(input logic                  sign,
                                    input logic [F32_EXP_W-1:0]  exp,
                                    input logic [F32_MANT_W-1:0] mant);
    f32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.mant = mant;
    return f;
  endfunction

endpackage

// File: rtl/fix2sgl_lzc.sv
// rtl/fix2sgl_lzc.sv - combinational leading-zero counter
//
// Purpose: counts the leading zeros of a W-bit word (priority encoder on the
// most significant set bit). An all-zero word reports W-1; callers that care
// about zero carry their own zero flag.
// Ports:
//   value  in  W   word to scan
//   count  out CW  number of zeros above the most significant 1 (0..W-1)
module fix2sgl_lzc #(
  parameter int W  = 16,
  parameter int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  // Ascending scan: the highest set bit is visited last and therefore wins.
  always_comb begin
    count = CW'(W - 1);
    for (int i = 0; i < W; i++) begin
      if (value[i]) begin
        count = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fix_to_single_pipe.sv
// rtl/fix_to_single_pipe.sv - 3-stage valid/ready fixed-point to IEEE 754 single converter
//
// Purpose: converts a signed (two's-complement) or unsigned INT_WIDTH.FRACT_WIDTH
// fixed-point word to single precision. Stage 1 splits sign and magnitude,
// stage 2 normalises, stage 3 assembles the float into the output register.
// All stages advance together on en = !out_valid || out_ready.
// Build option: FIX2SGL_ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the magnitude is truncated toward zero.
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous active-high reset
//   in_valid     in   1   input word valid
//   in_ready     out  1   converter accepts a word this cycle
//   fixed_point  in   W   fixed-point input, W = INT_WIDTH + FRACT_WIDTH
//   out_valid    out  1   result valid
//   out_ready    in   1   downstream accepts the result
//   single       out  32  IEEE 754 single-precision result
//   inexact      out  1   discarded low bits were non-zero (qualified by out_valid)
module fix_to_single_pipe
  import fix2sgl_pkg::*;
#(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4,
  parameter int SIGNED      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] fixed_point,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      single,
  output logic                             inexact
);

  localparam int W        = INT_WIDTH + FRACT_WIDTH;
  localparam int CW       = (W > 1) ? $clog2(W) : 1;
  // Normalised word with 25 zero bits appended: mantissa, guard and sticky
  // then sit at fixed positions whatever W is, and widths below 24 give
  // guard = sticky = 0 automatically.
  localparam int EXT_W    = W + 25;
  localparam int EXP_BASE = F32_BIAS + INT_WIDTH - 1;

  if (W > 64 || INT_WIDTH < 1 || FRACT_WIDTH < 0) begin : g_bad_cfg
    $error("fix_to_single_pipe: INT_WIDTH+FRACT_WIDTH must be 1..64");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: sign and magnitude.
  logic         sign_c;
  logic [W-1:0] mag_c;
  assign sign_c = (SIGNED != 0) ? fixed_point[W-1] : 1'b0;
  // The most negative input negates to 2^(W-1), which is the right unsigned magnitude.
  assign mag_c  = sign_c ? -fixed_point : fixed_point;

  logic         s1_valid, s1_sign, s1_zero;
  logic [W-1:0] s1_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= sign_c;
      s1_zero  <= (fixed_point == '0);
      s1_mag   <= mag_c;
    end
  end

  // Stage 2: normalise so the leading 1 lands on bit W-1.
  logic [CW-1:0] lzc_c;

  fix2sgl_lzc #(.W(W), .CW(CW)) u_lzc (
    .value (s1_mag),
    .count (lzc_c)
  );

  logic          s2_valid, s2_sign, s2_zero;
  logic [CW-1:0] s2_lzc;
  logic [W-1:0]  s2_norm;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_lzc   <= '0;
      s2_norm  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_lzc   <= lzc_c;
      s2_norm  <= s1_mag << lzc_c;
    end
  end

  // Stage 3: assemble exponent and mantissa into the output register.
  logic [EXT_W-1:0] ext;
  logic [22:0]      mant_t, mant_r;
  logic             guard, sticky;
  logic [8:0]       exp_c, exp_r;
  logic             exp_unused;
  f32_t             result;

  assign ext    = {s2_norm, 25'b0};
  assign mant_t = ext[W+23:W+1];
  assign guard  = ext[W];
  assign sticky = |ext[W-1:0];
  assign exp_c  = 9'(EXP_BASE) - 9'(s2_lzc);

`ifdef FIX2SGL_ROUND_NEAREST_EN
  logic rnd_inc, rnd_carry;
  assign rnd_inc = guard && (sticky || mant_t[0]);
  // A carry out of the mantissa wraps it to zero and bumps the exponent.
  assign {rnd_carry, mant_r} = {1'b0, mant_t} + 24'(rnd_inc);
  assign exp_r = exp_c + 9'(rnd_carry);
`else
  assign mant_r = mant_t;
  assign exp_r  = exp_c;
`endif

  // The exponent stays within 64..191 for every legal configuration, so bit 8 is never set.
  assign exp_unused = exp_r[8];
  assign result     = s2_zero ? '0 : f32_pack(s2_sign, exp_r[7:0], mant_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      single    <= '0;
      inexact   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      single    <= result;
      inexact   <= !s2_zero && (guard || sticky);
    end
  end

endmodule

// File: tb/tb_fix_to_single_pipe.sv
// tb/tb_fix_to_single_pipe.sv - self-checking bench for fix_to_single_pipe
module tb_fix_to_single_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DUT A: default 12.4 signed
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_inexact;
    logic [15:0] a_fp = '0;
    logic [31:0] a_single;
    // DUT B: 12.4 unsigned
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_inexact;
    logic [15:0] b_fp = '0;
    logic [31:0] b_single;
    // DUT C: 32.0 unsigned
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_inexact;
    logic [31:0] c_fp = '0;
    logic [31:0] c_single;

    fix_to_single_pipe #(.INT_WIDTH(12), .FRACT_WIDTH(4), .SIGNED(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .fixed_point(a_fp), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .single(a_single), .inexact(a_inexact));

    fix_to_single_pipe #(.INT_WIDTH(12), .FRACT_WIDTH(4), .SIGNED(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .fixed_point(b_fp), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .single(b_single), .inexact(b_inexact));

    fix_to_single_pipe #(.INT_WIDTH(32), .FRACT_WIDTH(0), .SIGNED(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .fixed_point(c_fp), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .single(c_single), .inexact(c_inexact));

    // Reference: exact value as a double, then narrowed to single by field arithmetic.
    // Returns {inexact, single}.
    function automatic logic [32:0] ref_conv(input longint val, input int fract);
        real         r;
        logic [63:0] b;
        logic [10:0] e;
        logic [22:0] kept;
        logic        g, s, neg;
        logic [30:0] body;
        longint      mag;
        if (val == 0) return 33'd0;
        neg = (val < 0);
        mag = neg ? -val : val;
        r = mag;
        for (int i = 0; i < fract; i++) r = r / 2.0;
        b    = $realtobits(r);
        e    = b[62:52];
        kept = b[51:29];
        g    = b[28];
        s    = |b[27:0];
        body = {8'(e - 11'd896), kept};
`ifdef FIX2SGL_ROUND_NEAREST_EN
        if (g && (s || kept[0])) body = body + 31'd1;
`endif
        return {g | s, neg, body};
    endfunction

    // Outstanding words of DUT A: result plus the number of enabled clock edges
    // seen since acceptance; a word is presented once it has seen three.
    typedef struct {
        logic [31:0] f;
        logic        ix;
        int          cnt;
    } ent_t;
    ent_t        qa[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_single = '0;
    logic        prev_inexact = 1'b0;

    task automatic cyc_a(input logic v, input logic [15:0] d, input logic ordy, output logic acc);
        logic        exp_v, en_m;
        logic [32:0] r;
        ent_t        e;
        a_in_valid  = v;
        a_fp        = d;
        a_out_ready = ordy;
        #1;
        exp_v = (qa.size() > 0) && (qa[0].cnt >= 3);
        en_m  = !exp_v || ordy;
        chk("a_in_ready", a_in_ready, en_m);
        chk("a_out_valid", a_out_valid, exp_v);
        if (exp_v) begin
            chk("a_single", a_single, qa[0].f);
            chk("a_inexact", a_inexact, qa[0].ix);
        end
        if (prev_stall) begin
            chk("a_stall_hold_single", a_single, prev_single);
            chk("a_stall_hold_inexact", a_inexact, prev_inexact);
        end
        prev_stall   = exp_v && !ordy;
        prev_single  = a_single;
        prev_inexact = a_inexact;
        if (exp_v && ordy) void'(qa.pop_front());
        if (en_m) foreach (qa[i]) qa[i].cnt++;
        acc = v && en_m;
        if (acc) begin
            r     = ref_conv(longint'($signed(d)), 4);
            e.f   = r[31:0];
            e.ix  = r[32];
            e.cnt = 1;
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_all();
        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        prev_stall = 1'b0;
        #1;
        chk("rst_a_out_valid", a_out_valid, 1'b0);
        chk("rst_a_single", a_single, 32'h0);
        chk("rst_a_inexact", a_inexact, 1'b0);
        chk("rst_a_in_ready", a_in_ready, 1'b1);
        chk("rst_c_out_valid", c_out_valid, 1'b0);
    endtask

    task automatic conv_b(input logic [15:0] d, input logic [32:0] want);
        b_in_valid = 1'b1;
        b_fp = d;
        #1;
        chk("b_in_ready", b_in_ready, 1'b1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b_early_valid", b_out_valid, 1'b0);
        @(posedge clk); #1;
        chk("b_out_valid", b_out_valid, 1'b1);
        chk("b_single", b_single, want[31:0]);
        chk("b_inexact", b_inexact, want[32]);
        @(posedge clk); #1;
        chk("b_drained", b_out_valid, 1'b0);
    endtask

    task automatic conv_c(input logic [31:0] d, input logic [32:0] want);
        c_in_valid = 1'b1;
        c_fp = d;
        #1;
        chk("c_in_ready", c_in_ready, 1'b1);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("c_early_valid", c_out_valid, 1'b0);
        @(posedge clk); #1;
        chk("c_out_valid", c_out_valid, 1'b1);
        chk("c_single", c_single, want[31:0]);
        chk("c_inexact", c_inexact, want[32]);
        @(posedge clk); #1;
        chk("c_drained", c_out_valid, 1'b0);
    endtask

    initial begin
        logic        acc;
        int          sent;
        logic [15:0] bp_words [5];
        logic [31:0] cv;

        // Reset state
        rst_all();

        // Back-to-back directed words, then drain
        cyc_a(1'b1, 16'h0010, 1'b1, acc);
        cyc_a(1'b1, 16'hFFF0, 1'b1, acc);
        cyc_a(1'b1, 16'h8000, 1'b1, acc);
        cyc_a(1'b1, 16'h0001, 1'b1, acc);
        for (int i = 0; i < 5; i++) cyc_a(1'b0, 16'h0, 1'b1, acc);

        // Zero input
        cyc_a(1'b1, 16'h0000, 1'b1, acc);
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 16'h0, 1'b1, acc);

        // Unsigned 12.4 and wide 32.0 directed points
        conv_b(16'hFFF0, {1'b0, 32'h457F_F000});
`ifdef FIX2SGL_ROUND_NEAREST_EN
        conv_c(32'h01FF_FFFF, {1'b1, 32'h4C00_0000});
`else
        conv_c(32'h01FF_FFFF, {1'b1, 32'h4BFF_FFFF});
`endif
        conv_c(32'h0100_0001, {1'b1, 32'h4B80_0000});

        // Backpressure: 5 words with out_ready pattern 1,0,0,1,0,0,...
        for (int i = 0; i < 5; i++) bp_words[i] = 16'($urandom);
        sent = 0;
        for (int c = 0; c < 80 && (sent < 5 || qa.size() > 0); c++) begin
            if (sent < 5) cyc_a(1'b1, bp_words[sent], (c % 3) == 0, acc);
            else          cyc_a(1'b0, 16'h0, (c % 3) == 0, acc);
            if (acc) sent++;
        end
        chk("bp_all_sent", sent, 5);
        chk("bp_drained", qa.size(), 0);

        // Reset with two words in flight
        cyc_a(1'b1, 16'($urandom), 1'b1, acc);
        cyc_a(1'b1, 16'($urandom), 1'b1, acc);
        rst_all();
        cyc_a(1'b1, 16'h0123, 1'b1, acc);
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 16'h0, 1'b1, acc);

        // Random traffic on DUT A with random backpressure
        for (int c = 0; c < 300; c++) begin
            cyc_a(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, acc);
        end
        for (int c = 0; c < 40 && qa.size() > 0; c++) cyc_a(1'b0, 16'h0, 1'b1, acc);
        chk("rand_drained", qa.size(), 0);

        // Random single conversions on the unsigned and wide configurations
        for (int i = 0; i < 10; i++) begin
            cv = $urandom;
            conv_b(cv[15:0], ref_conv(longint'({48'b0, cv[15:0]}), 4));
        end
        for (int i = 0; i < 30; i++) begin
            cv = $urandom >> $urandom_range(0, 31);
            conv_c(cv, ref_conv(longint'({32'b0, cv}), 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fix_to_single_pipe.md
Name: fix_to_single_pipe

Overview:
- Pipelined, parametrised converter from signed or unsigned fixed-point to IEEE 754 single precision.
- Sits between the fixed-point Madgwick datapath and float consumers such as fastInvSqrt and bus readout.
- Generalises the combinational converter with two's-complement sign handling, optional round-to-nearest-even, and a 3-stage valid/ready pipeline with backpressure.

Parameters:
- INT_WIDTH, 12, integer bits including the sign bit when SIGNED=1; range 1..64.
- FRACT_WIDTH, 4, fractional bits; range 0..63. The constraint INT_WIDTH+FRACT_WIDTH (W) ≤ 64 is checked at elaboration.
- SIGNED, 1, 1 means two's-complement input; 0 means unsigned input.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous and active-high; one clock domain, clk.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word this cycle.
- fixed_point  in  W  fixed-point input.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- single  out  32  IEEE 754 result.
- inexact  out  1  result differs from the exact input value, i.e. discarded bits were non-zero. Qualified by out_valid.

Behaviour:
- Reset values: out_valid=0, single=0, inexact=0, all stage valid bits=0. in_ready=1 on the cycle after reset deasserts.
- Global advance: en = !out_valid || out_ready. in_ready = en. Every stage register loads only when en=1, and a stage valid bit takes its upstream valid when en=1. Bubbles are not compressed.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: exactly 3 clk from input transfer to out_valid when unstalled. Throughput is 1 word/clk.
- S1 (sign/magnitude):
  - sign = SIGNED ? fixed_point[W-1] : 0.
  - mag = sign ? -fixed_point : fixed_point, held as W-bit unsigned.
  - The most negative input gives mag = 2^(W-1), which is correct unsigned.
  - zero flag = (fixed_point == 0).
- S2 (normalise):
  - lzc = leading-zero count of mag, 0..W-1.
  - norm = mag << lzc, so the leading 1 is at bit W-1.
- S3 (assemble):
  - exp = 127 + INT_WIDTH - 1 - lzc, computed in 9 bits. It never overflows or underflows within the parameter range.
  - Fraction = norm[W-2:0], left-aligned to 23 bits.
  - If W-1 ≤ 23: zero-pad; inexact=0.
  - If W-1 > 23: guard = next bit below the kept field, sticky = OR of remaining bits, inexact = guard|sticky.
  - Rounding per the optional feature.
  - Round carry-out: mantissa wraps to 0 and exp increments by 1.
- Zero input: single = 32'h0000_0000 and inexact=0. Negative zero is never produced.
- Stall: while out_valid && !out_ready, single and inexact hold stable and no stage changes. in_valid may be held high across the stall without duplication.
- Reset mid-operation: all in-flight words are discarded. No out_valid is asserted until fresh inputs have traversed 3 stages.
- Simultaneous output and input transfer in the same cycle is permitted and required for full throughput.

Optional Feature:
- Macro FIX2SGL_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment the mantissa when guard && (sticky || mantissa LSB).
- Undefined: truncation toward zero of the magnitude; no increment, no carry path.
- The inexact port and its behaviour are identical in both builds.

Decomposition:
- Package fix2sgl_pkg holds:
  - localparams F32_BIAS=127, F32_MANT_W=23, F32_EXP_W=8.
  - typedef f32_t, a packed struct {sign, exp[7:0], mant[22:0]}.
  - function f32_pack.
- One sub-module, fix2sgl_lzc: parametrised width W, combinational leading-zero counter (priority encoder), instantiated in S2.

Test Plan:
- Defaults (12.4 signed), out_ready=1, inputs 16'h0010, 16'hFFF0, 16'h8000, 16'h0001 back-to-back:
  - Expect 32'h3F80_0000, 32'hBF80_0000, 32'hC500_0000, 32'h3D80_0000 on consecutive cycles, first at 3 clk after input.
  - inexact=0 throughout.
- Defaults, input 16'h0000 → 32'h0000_0000 with inexact=0. SIGNED=0 with input 16'hFFF0 → 32'h457F_F000.
- INT_WIDTH=32, FRACT_WIDTH=0, SIGNED=0, input 32'h01FF_FFFF:
  - With macro: 32'h4C00_0000.
  - Without macro: 32'h4BFF_FFFF.
  - inexact=1 in both builds.
- Same configuration, input 32'h0100_0001 (tie, even LSB) → 32'h4B80_0000 and inexact=1 in both builds.
- Backpressure:
  - Stream 5 words with out_ready toggling 1,0,0,1,…
  - Expect no loss, duplication or reordering.
  - single stable while stalled; in_ready=0 exactly when out_valid && !out_ready.
- Assert rst for 1 clk with 2 words in flight:
  - out_valid=0 from the next cycle.
  - The next result appears 3 clk after the first post-reset input transfer.
